// File: rtl/sevenseg_scan_ctl.sv
// Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
// Stores one control word per digit, scans with an all-off guard interval and per-digit blink.
module sevenseg_scan_ctl #(
  parameter int unsigned N         = 8,
  parameter int unsigned DIVISOR   = 100000,
  parameter int unsigned GUARD     = 4,
  parameter int unsigned BLINK_DIV = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [2:0]   waddr,
  input  logic [6:0]   wdata,
  input  logic [N-1:0] blink_mask,
  output logic [N-1:0] an_n,
  output logic [6:0]   dig,
  output logic [2:0]   idx
);

  localparam int unsigned PW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] TickVal   = PW'(DIVISOR - 1);
  localparam logic [PW-1:0] GuardVal  = PW'(GUARD);
  localparam logic [2:0]    LastIdx   = 3'(N - 1);
  localparam logic [BW-1:0] LastRound = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    Blank     = 7'b1000000;

  logic [PW-1:0] psc_q, psc_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] rnd_q, rnd_d;
  logic          phase_q, phase_d;
  logic [6:0]    reg_q [N];
  logic [6:0]    reg_d [N];
  logic [N-1:0]  an_n_q, an_n_d;
  logic [6:0]    dig_q, dig_d;
  logic          tick;

  assign tick = (psc_q == TickVal);

  always_comb begin
    psc_d   = tick ? '0 : psc_q + 1'b1;
    idx_d   = idx_q;
    rnd_d   = rnd_q;
    phase_d = phase_q;
    if (tick) begin
      if (idx_q == LastIdx) begin
        idx_d = '0;
        // Round wrap: advance the blink round counter, toggling phase at its end.
        if (rnd_q == LastRound) begin
          rnd_d   = '0;
          phase_d = ~phase_q;
        end else begin
          rnd_d = rnd_q + 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      reg_d[i] = reg_q[i];
      if (we && (waddr == 3'(i))) reg_d[i] = wdata;
    end
  end

  // Outputs are decoded from the current state and registered.
  always_comb begin
    an_n_d = '1;
    dig_d  = Blank;
    for (int i = 0; i < int'(N); i++) begin
      if (idx_q == 3'(i)) begin
        an_n_d[i] = (psc_q < GuardVal);
        dig_d     = reg_q[i];
        dig_d[6]  = reg_q[i][6] | (phase_q & blink_mask[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q   <= '0;
      idx_q   <= '0;
      rnd_q   <= '0;
      phase_q <= 1'b0;
      an_n_q  <= '1;
      dig_q   <= Blank;
      for (int i = 0; i < int'(N); i++) reg_q[i] <= Blank;
    end else begin
      psc_q   <= psc_d;
      idx_q   <= idx_d;
      rnd_q   <= rnd_d;
      phase_q <= phase_d;
      an_n_q  <= an_n_d;
      dig_q   <= dig_d;
      for (int i = 0; i < int'(N); i++) reg_q[i] <= reg_d[i];
    end
  end

  assign an_n = an_n_q;
  assign dig  = dig_q;
  assign idx  = idx_q;

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// Self-checking bench for sevenseg_scan_ctl: constant vector table, directed corner cases
// and randomized writes checked against a time-based reference model.
module tb_sevenseg_scan_ctl;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int G  = 2;
  localparam int BD = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         we;
  logic [2:0]   waddr;
  logic [6:0]   wdata;
  logic [N-1:0] blink_mask;
  logic [N-1:0] an_n;
  logic [6:0]   dig;
  logic [2:0]   idx;

  sevenseg_scan_ctl #(
    .N         (N),
    .DIVISOR   (D),
    .GUARD     (G),
    .BLINK_DIV (BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .blink_mask (blink_mask),
    .an_n       (an_n),
    .dig        (dig),
    .idx        (idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: t = cycles since reset; every scan quantity follows from t by arithmetic.
  int         t = 0;
  logic [6:0] mreg [N];

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [2:0] ix;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic logic [3:0] exp_an(input int tt);
    if ((tt % D) < G) return 4'hf;
    return ~(4'b0001 << ((tt / D) % N));
  endfunction

  function automatic logic [6:0] exp_dig(input int tt);
    int         i;
    int         ph;
    logic [6:0] v;
    i  = (tt / D) % N;
    ph = ((tt / D) / N / BD) % 2;
    v  = mreg[i];
    if (ph == 1 && blink_mask[i]) v[6] = 1'b1;
    return v;
  endfunction

  task automatic step(input logic r, input logic w, input logic [2:0] a, input logic [6:0] d);
    logic [3:0] ea;
    logic [6:0] ed;
    logic [2:0] ei;
    rst   = r;
    we    = w;
    waddr = a;
    wdata = d;
    ea = r ? 4'hf : exp_an(t);
    ed = r ? 7'h40 : exp_dig(t);
    ei = r ? 3'd0 : 3'(((t + 1) / D) % N);
    @(posedge clk);
    #1;
    chk("an_n", int'(an_n), int'(ea));
    chk("dig", int'(dig), int'(ed));
    chk("idx", int'(idx), int'(ei));
    if (r) begin
      t = 0;
      for (int i = 0; i < N; i++) mreg[i] = 7'h40;
    end else begin
      if (w && int'(a) < N) mreg[a] = d;
      t++;
    end
    rst = 1'b0;
    we  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 7'h00);
  endtask

  initial begin
    int         seen03;
    int         seen43;
    int         mi;
    int         guard;
    logic       done;
    logic [3:0] sel;

    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; blink_mask = '0;
    for (int i = 0; i < N; i++) mreg[i] = 7'h40;

    vecs[0]  = '{1,  4'b1111, 3'd0};
    vecs[1]  = '{2,  4'b1111, 3'd0};
    vecs[2]  = '{3,  4'b1110, 3'd0};
    vecs[3]  = '{8,  4'b1110, 3'd1};
    vecs[4]  = '{9,  4'b1111, 3'd1};
    vecs[5]  = '{11, 4'b1101, 3'd1};
    vecs[6]  = '{16, 4'b1101, 3'd2};
    vecs[7]  = '{19, 4'b1011, 3'd2};
    vecs[8]  = '{27, 4'b0111, 3'd3};
    vecs[9]  = '{32, 4'b0111, 3'd0};
    vecs[10] = '{33, 4'b1111, 3'd0};

    // Reset and plain scan against the constant table.
    step(1'b1, 1'b0, 3'd0, 7'h00);
    step(1'b1, 1'b0, 3'd0, 7'h00);
    chk("reset_an", int'(an_n), 'hf);
    chk("reset_dig", int'(dig), 'h40);
    chk("reset_idx", int'(idx), 0);
    for (int k = 1; k <= 33; k++) begin
      step(1'b0, 1'b0, 3'd0, 7'h00);
      foreach (vecs[v]) begin
        if (vecs[v].cyc == k) begin
          chk("vec_an", int'(an_n), int'(vecs[v].an));
          chk("vec_idx", int'(idx), int'(vecs[v].ix));
          chk("vec_dig", int'(dig), 'h40);
        end
      end
    end

    // Writes to digits 2 and 0.
    step(1'b0, 1'b1, 3'd2, 7'h05);
    step(1'b0, 1'b1, 3'd0, 7'h20);
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (an_n == 4'b1011) chk("dig2_written", int'(dig), 'h05);
      if (an_n == 4'b1110) chk("dig0_written", int'(dig), 'h20);
      if (an_n == 4'b1101) chk("dig1_blank", int'(dig), 'h40);
    end

    // Out-of-range write must be ignored.
    step(1'b0, 1'b1, 3'd5, 7'h7f);
    for (int i = 0; i < 32; i++) begin
      idle(1);
      if (an_n == 4'b0111) chk("dig3_oob", int'(dig), 'h40);
    end

    // Blink on digit 1 only.
    step(1'b0, 1'b1, 3'd1, 7'h03);
    blink_mask = 4'b0010;
    seen03 = 0;
    seen43 = 0;
    for (int i = 0; i < 4 * N * D * BD; i++) begin
      idle(1);
      if (an_n == 4'b1101) begin
        if (dig == 7'h03) seen03++;
        if (dig == 7'h43) seen43++;
      end
      if (an_n == 4'b1110) chk("dig0_no_blink", int'(dig[6]), 0);
    end
    chk("blink_saw_03", int'(seen03 > 0), 1);
    chk("blink_saw_43", int'(seen43 > 0), 1);
    blink_mask = 4'b0000;

    // Write to the active digit exactly on the tick cycle.
    while ((t % D) != D - 1) idle(1);
    mi = (t / D) % N;
    step(1'b0, 1'b1, 3'(mi), 7'h2a);
    sel   = ~(4'b0001 << mi);
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 2 * N * D) begin
      idle(1);
      guard++;
      if (an_n == sel) begin
        chk("tick_write", int'(dig), 'h2a);
        done = 1'b1;
      end
    end
    chk("tick_write_seen", int'(done), 1);

    // Reset mid-slot on digit 3 with a coincident write.
    while (!(((t / D) % N) == 3 && (t % D) == 4)) idle(1);
    step(1'b1, 1'b1, 3'd3, 7'h11);
    chk("rst_mid_an", int'(an_n), 'hf);
    chk("rst_mid_dig", int'(dig), 'h40);
    chk("rst_mid_idx", int'(idx), 0);
    for (int i = 0; i < N * D + 2; i++) begin
      idle(1);
      if (an_n == 4'b0111) chk("rst_write_lost", int'(dig), 'h40);
    end

    // Randomized writes, mask changes and occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
      step(1'b0 == ($urandom_range(0, 249) != 0), 1'($urandom), 3'($urandom), 7'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
